// File: rtl/player_link_rx_pkg.sv
// Shared frame layout, FSM encoding and parity helper for the player-2 board-to-board link.
// The slave-side transmitter builds its frames from the same definitions.
package player_link_rx_pkg;

  localparam int LINK_DATA_BITS = 5;

  // Button order inside a frame, LSB (first on the wire) first.
  localparam int BIT_UP     = 0;
  localparam int BIT_DOWN   = 1;
  localparam int BIT_LEFT   = 2;
  localparam int BIT_RIGHT  = 3;
  localparam int BIT_ATTACK = 4;

  // Even parity: XOR over data and parity bit must reduce to this value.
  localparam logic PARITY_RESIDUE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } link_state_e;

  function automatic logic parity_ok(input logic [LINK_DATA_BITS-1:0] data, input logic par);
    return ((^data) ^ par) == PARITY_RESIDUE;
  endfunction

endpackage

// File: rtl/link_bit_timer.sv
// Loadable down-counter producing a one-cycle sample tick in the middle of each serial bit.
// A half-bit load centres the first tick on the start bit; each tick reloads a full bit.
module link_bit_timer #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load_half,
  input  logic i_run,
  output logic o_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_run && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load_half) begin
      r_cnt <= HALF_LOAD;
    end else if (o_tick) begin
      r_cnt <= FULL_LOAD;
    end else if (i_run) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/player_link_rx.sv
// Player-2 link receiver: synchronises rx, decodes start/5 data/parity/stop frames, holds the
// last good button state and drops it if no good frame arrives within TIMEOUT_CLKS.
module player_link_rx
  import player_link_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int TIMEOUT_CLKS = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       input_player2UpBtn,
  output logic       input_player2DownBtn,
  output logic       input_player2LeftBtn,
  output logic       input_player2RightBtn,
  output logic       input_player2AttackBtn,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       link_up,
  output logic [2:0] dbg_state
);

  localparam int TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CLKS - 1);

  logic                      r_rx_meta;
  logic                      r_rx_sync;
  link_state_e               r_state;
  link_state_e               w_next_state;
  logic [2:0]                r_bit_idx;
  logic [LINK_DATA_BITS-1:0] r_data;
  logic                      r_par;
  logic [LINK_DATA_BITS-1:0] r_btn;
  logic                      r_frame_valid;
  logic                      r_frame_err;
  logic                      r_link_up;
  logic [TW-1:0]             r_to_cnt;
  logic                      w_load_half;
  logic                      w_run;
  logic                      w_tick;
  logic                      w_good;
  logic                      w_bad;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_run = (r_state != ST_IDLE);

  link_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk         (clk),
    .rst         (rst),
    .i_load_half (w_load_half),
    .i_run       (w_run),
    .o_tick      (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_load_half  = 1'b0;
    w_good       = 1'b0;
    w_bad        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_rx_sync) begin
          w_next_state = ST_START;
          w_load_half  = 1'b1;
        end
      end
      ST_START: begin
        // A high line at mid start bit was only a glitch.
        if (w_tick) w_next_state = r_rx_sync ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_tick && (r_bit_idx == 3'(LINK_DATA_BITS - 1))) w_next_state = ST_PARITY;
      end
      ST_PARITY: begin
        if (w_tick) w_next_state = ST_STOP;
      end
      ST_STOP: begin
        if (w_tick) begin
          w_next_state = ST_IDLE;
          if (r_rx_sync && parity_ok(r_data, r_par)) w_good = 1'b1;
          else                                       w_bad  = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Data arrives LSB first, so shifting in from the top leaves d0 in bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_idx <= '0;
      r_data    <= '0;
      r_par     <= 1'b0;
    end else if (w_tick) begin
      case (r_state)
        ST_START: r_bit_idx <= '0;
        ST_DATA: begin
          r_data    <= {r_rx_sync, r_data[LINK_DATA_BITS-1:1]};
          r_bit_idx <= r_bit_idx + 1'b1;
        end
        ST_PARITY: r_par <= r_rx_sync;
        default: ;
      endcase
    end
  end

  // A good frame takes priority over timeout expiry in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_btn         <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_link_up     <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      r_frame_valid <= w_good;
      r_frame_err   <= w_bad;
      if (w_good) begin
        r_btn     <= r_data;
        r_link_up <= 1'b1;
        r_to_cnt  <= '0;
      end else begin
        if (r_to_cnt != TO_MAX) r_to_cnt <= r_to_cnt + 1'b1;
        if (r_to_cnt == TO_MAX) begin
          r_btn     <= '0;
          r_link_up <= 1'b0;
        end
      end
    end
  end

  assign input_player2UpBtn     = r_btn[BIT_UP];
  assign input_player2DownBtn   = r_btn[BIT_DOWN];
  assign input_player2LeftBtn   = r_btn[BIT_LEFT];
  assign input_player2RightBtn  = r_btn[BIT_RIGHT];
  assign input_player2AttackBtn = r_btn[BIT_ATTACK];
  assign frame_valid            = r_frame_valid;
  assign frame_err              = r_frame_err;
  assign link_up                = r_link_up;
  assign dbg_state              = r_state;

endmodule

// File: tb/tb_player_link_rx.sv
// Directed bench for player_link_rx: good/bad frames, glitch, timeout, mid-frame reset, and
// back-to-back frames after a stop-bit error.
module tb_player_link_rx;
  import player_link_rx_pkg::*;

  localparam int CPB = 16;
  localparam int TO  = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       up_btn, down_btn, left_btn, right_btn, attack_btn;
  logic       frame_valid, frame_err, link_up;
  logic [2:0] dbg_state;
  logic [4:0] w_btns;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int valid_cyc = 0;

  player_link_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .rx                     (rx),
    .input_player2UpBtn     (up_btn),
    .input_player2DownBtn   (down_btn),
    .input_player2LeftBtn   (left_btn),
    .input_player2RightBtn  (right_btn),
    .input_player2AttackBtn (attack_btn),
    .frame_valid            (frame_valid),
    .frame_err              (frame_err),
    .link_up                (link_up),
    .dbg_state              (dbg_state)
  );

  assign w_btns = {attack_btn, right_btn, left_btn, down_btn, up_btn};

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Pulse monitor: a pulse stuck high for several cycles counts several times.
  always @(negedge clk) begin
    if (frame_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
    if (frame_err) err_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Driver: start(0), d0..d4, parity, stop, each CPB clocks, changed on negedges.
  task automatic send_frame(input logic [4:0] d, input logic par, input logic stop);
    logic [7:0] bits;
    bits = {stop, par, d, 1'b0};
    for (int i = 0; i < 8; i++) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (w_btns !== 5'b00000) begin errors++; $display("FAIL reset_btns: got %b want %b", w_btns, 5'b00000); end
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL reset_link_up: got %b want 0", link_up); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", frame_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", frame_err); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_good_frame();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(5'b10101, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (w_btns !== 5'b10101) begin errors++; $display("FAIL good_btns: got %b want %b", w_btns, 5'b10101); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL good_valid_pulses: got %0d want 1", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL good_err_pulses: got %0d want 0", err_cnt - e0); end
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL good_link_up: got %b want 1", link_up); end
  endtask

  task automatic test_parity_err();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(5'b10101, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL parity_err_pulses: got %0d want 1", err_cnt - e0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL parity_valid_pulses: got %0d want 0", valid_cnt - v0); end
    checks++; if (w_btns !== 5'b10101) begin errors++; $display("FAIL parity_btns_held: got %b want %b", w_btns, 5'b10101); end
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL parity_link_up: got %b want 1", link_up); end
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (dbg_state !== ST_START) begin errors++; $display("FAIL glitch_enters_start: got %0d want %0d", dbg_state, ST_START); end
    repeat (20) @(negedge clk);
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL glitch_back_idle: got %0d want %0d", dbg_state, ST_IDLE); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d want 0", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL glitch_err: got %0d want 0", err_cnt - e0); end
    checks++; if (w_btns !== 5'b10101) begin errors++; $display("FAIL glitch_btns_held: got %b want %b", w_btns, 5'b10101); end
  endtask

  task automatic test_timeout();
    int target;
    send_frame(5'b00011, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++; if (w_btns !== 5'b00011) begin errors++; $display("FAIL timeout_frame_btns: got %b want %b", w_btns, 5'b00011); end
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL timeout_frame_link_up: got %b want 1", link_up); end
    // Counter is 0 after the accepting edge and reaches TO-1 after TO-1 more edges.
    target = valid_cyc + TO - 1;
    for (int k = 0; k < TO + 100 && cyc < target; k++) @(negedge clk);
    checks++; if (cyc !== target) begin errors++; $display("FAIL timeout_wait: reached cycle %0d want %0d", cyc, target); end
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL timeout_before_expiry: link_up got %b want 1", link_up); end
    checks++; if (w_btns !== 5'b00011) begin errors++; $display("FAIL timeout_before_btns: got %b want %b", w_btns, 5'b00011); end
    @(negedge clk);
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL timeout_link_up: got %b want 0", link_up); end
    checks++; if (w_btns !== 5'b00000) begin errors++; $display("FAIL timeout_btns: got %b want %b", w_btns, 5'b00000); end
  endtask

  task automatic test_reset_mid_frame();
    int v0, e0;
    send_frame(5'b01100, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++; if (w_btns !== 5'b01100) begin errors++; $display("FAIL midrst_pre_btns: got %b want %b", w_btns, 5'b01100); end
    v0 = valid_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB + CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (CPB / 2 - 2 + 4 * CPB) @(negedge clk);
    checks++; if (w_btns !== 5'b00000) begin errors++; $display("FAIL midrst_btns: got %b want %b", w_btns, 5'b00000); end
    checks++; if (link_up !== 1'b0) begin errors++; $display("FAIL midrst_link_up: got %b want 0", link_up); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL midrst_valid: got %0d want 0", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin errors++; $display("FAIL midrst_err: got %0d want 0", err_cnt - e0); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL midrst_state: got %0d want %0d", dbg_state, ST_IDLE); end
    send_frame(5'b11111, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    checks++; if (w_btns !== 5'b11111) begin errors++; $display("FAIL midrst_new_btns: got %b want %b", w_btns, 5'b11111); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL midrst_new_valid: got %0d want 1", valid_cnt - v0); end
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL midrst_new_link_up: got %b want 1", link_up); end
  endtask

  task automatic test_back_to_back();
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(5'b01010, 1'b0, 1'b0);
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL stop_err_pulses: got %0d want 1", err_cnt - e0); end
    checks++; if (valid_cnt - v0 !== 0) begin errors++; $display("FAIL stop_err_valid: got %0d want 0", valid_cnt - v0); end
    checks++; if (w_btns !== 5'b11111) begin errors++; $display("FAIL stop_err_btns_held: got %b want %b", w_btns, 5'b11111); end
    send_frame(5'b00110, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (w_btns !== 5'b00110) begin errors++; $display("FAIL b2b_btns: got %b want %b", w_btns, 5'b00110); end
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL b2b_valid: got %0d want 1", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL b2b_err: got %0d want 1", err_cnt - e0); end
    checks++; if (link_up !== 1'b1) begin errors++; $display("FAIL b2b_link_up: got %b want 1", link_up); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_err();
    test_glitch();
    test_timeout();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
